// File: rtl/eth_frame_checker_if.sv
// AXI-Stream receive bus carrying MAC RX frames into the frame checker.
interface eth_frame_checker_if #(
  parameter int unsigned P_DATA_WIDTH = 64
);
  logic [P_DATA_WIDTH-1:0]   tdata;
  logic [P_DATA_WIDTH/8-1:0] tkeep;
  logic                      tvalid;
  logic                      tlast;
  logic                      tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser);
  modport slave  (input  tdata, tkeep, tvalid, tlast, tuser);
endinterface

// File: rtl/eth_frame_checker.sv
// Receive-side checker for generator frames: validates length, header magic,
// sequence continuity and payload pattern, and keeps saturating statistics.
module eth_frame_checker #(
  parameter int unsigned P_DATA_WIDTH = 64,
  parameter logic [15:0] P_MIN_LENGTH = 16'd64,
  parameter logic [15:0] P_MAX_LENGTH = 16'd9600
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  eth_frame_checker_if.slave s_axis_rx,
  output logic               o_lock,
  output logic               o_chk_valid,
  output logic               o_chk_err,
  output logic [31:0]        o_frame_cnt,
  output logic [31:0]        o_err_cnt,
  output logic [31:0]        o_len_err_cnt,
  output logic [31:0]        o_seq_err_cnt,
  output logic [31:0]        o_data_err_cnt
);

  localparam int unsigned LP_KEEP_W   = P_DATA_WIDTH / 8;
  localparam int unsigned LP_POP_W    = $clog2(LP_KEEP_W + 1);
  localparam logic [15:0] LP_MAGIC    = 16'hA55A;
  localparam logic [16:0] LP_BYTE_SAT = 17'h0FFFF;
  localparam logic [31:0] LP_CNT_SAT  = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    S_HEAD = 1'b0,
    S_BODY = 1'b1
  } state_e;

  function automatic logic [LP_POP_W-1:0] keep_popcount(input logic [LP_KEEP_W-1:0] keep);
    logic [LP_POP_W-1:0] cnt;
    cnt = {LP_POP_W{1'b0}};
    for (int i = 0; i < int'(LP_KEEP_W); i++) begin
      cnt = cnt + LP_POP_W'(keep[i]);
    end
    return cnt;
  endfunction

  // A legal last-beat keep is a non-empty run of ones starting at bit 0.
  function automatic logic keep_contiguous(input logic [LP_KEEP_W-1:0] keep);
    logic [LP_KEEP_W-1:0] plus_one;
    plus_one = keep + {{(LP_KEEP_W-1){1'b0}}, 1'b1};
    return (keep != {LP_KEEP_W{1'b0}}) && ((keep & plus_one) == {LP_KEEP_W{1'b0}});
  endfunction

  function automatic logic payload_mismatch(input logic [P_DATA_WIDTH-1:0] data,
                                            input logic [LP_KEEP_W-1:0]    keep,
                                            input logic [P_DATA_WIDTH-1:0] expected);
    logic mis;
    mis = 1'b0;
    for (int i = 0; i < int'(LP_KEEP_W); i++) begin
      if (keep[i] && (data[8*i +: 8] != expected[8*i +: 8])) begin
        mis = 1'b1;
      end
    end
    return mis;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == LP_CNT_SAT) ? cnt : cnt + 32'd1;
  endfunction

  state_e        state_q, state_d;
  logic [31:0]   seq_q, seq_d;
  logic [15:0]   len_q, len_d;
  logic          hdr_ok_q, hdr_ok_d;
  logic          data_err_q, data_err_d;
  logic [16:0]   bytes_q, bytes_d;
  logic [31:0]   beat_q, beat_d;
  logic [31:0]   exp_seq_q, exp_seq_d;
  logic          lock_q, lock_d;
  logic          chk_valid_q, chk_valid_d;
  logic          chk_err_q, chk_err_d;
  logic [31:0]   frame_cnt_q, frame_cnt_d;
  logic [31:0]   err_cnt_q, err_cnt_d;
  logic [31:0]   len_err_cnt_q, len_err_cnt_d;
  logic [31:0]   seq_err_cnt_q, seq_err_cnt_d;
  logic [31:0]   data_err_cnt_q, data_err_cnt_d;

  logic          frame_done_s;
  logic          keep_err_s;
  logic          hdr_ok_s;
  logic [16:0]   bytes_add_s;
  logic [16:0]   bytes_sum_s;
  logic          len_err_s;
  logic          seq_err_s;
  logic          any_err_s;

  // The _d values of the per-frame fields are the final frame state on a tlast beat.
  always_comb begin
    state_d      = state_q;
    seq_d        = seq_q;
    len_d        = len_q;
    hdr_ok_d     = hdr_ok_q;
    data_err_d   = data_err_q;
    bytes_d      = bytes_q;
    beat_d       = beat_q;
    frame_done_s = 1'b0;
    keep_err_s   = s_axis_rx.tlast ? !keep_contiguous(s_axis_rx.tkeep)
                                   : (s_axis_rx.tkeep != {LP_KEEP_W{1'b1}});
    bytes_add_s  = s_axis_rx.tlast ? 17'(keep_popcount(s_axis_rx.tkeep)) : 17'(LP_KEEP_W);
    bytes_sum_s  = bytes_q + bytes_add_s;
    hdr_ok_s     = (s_axis_rx.tdata[63:48] == LP_MAGIC);
    case (state_q)
      S_HEAD: begin
        if (s_axis_rx.tvalid) begin
          seq_d        = s_axis_rx.tdata[31:0];
          len_d        = s_axis_rx.tdata[47:32];
          hdr_ok_d     = hdr_ok_s;
          data_err_d   = !hdr_ok_s || keep_err_s;
          bytes_d      = bytes_add_s;
          beat_d       = 32'd1;
          frame_done_s = s_axis_rx.tlast;
          state_d      = s_axis_rx.tlast ? S_HEAD : S_BODY;
        end else begin
          state_d = S_HEAD;
        end
      end
      S_BODY: begin
        if (s_axis_rx.tvalid) begin
          data_err_d   = data_err_q || keep_err_s ||
                         payload_mismatch(s_axis_rx.tdata, s_axis_rx.tkeep, {seq_q, beat_q});
          bytes_d      = (bytes_sum_s > LP_BYTE_SAT) ? LP_BYTE_SAT : bytes_sum_s;
          beat_d       = beat_q + 32'd1;
          frame_done_s = s_axis_rx.tlast;
          state_d      = s_axis_rx.tlast ? S_HEAD : S_BODY;
        end else begin
          state_d = S_BODY;
        end
      end
      default: begin
        state_d = S_HEAD;
      end
    endcase
  end

  // Frame verdict, sequence tracking, lock and statistics; clear overrides completion.
  always_comb begin
    len_err_s      = (bytes_d < {1'b0, P_MIN_LENGTH}) || (bytes_d > {1'b0, P_MAX_LENGTH}) ||
                     ({1'b0, len_d} != bytes_d);
    seq_err_s      = lock_q && hdr_ok_d && (seq_d != exp_seq_q);
    any_err_s      = s_axis_rx.tuser || len_err_s || seq_err_s || data_err_d;
    exp_seq_d      = exp_seq_q;
    lock_d         = lock_q;
    chk_valid_d    = 1'b0;
    chk_err_d      = 1'b0;
    frame_cnt_d    = frame_cnt_q;
    err_cnt_d      = err_cnt_q;
    len_err_cnt_d  = len_err_cnt_q;
    seq_err_cnt_d  = seq_err_cnt_q;
    data_err_cnt_d = data_err_cnt_q;
    if (frame_done_s) begin
      chk_valid_d = 1'b1;
      chk_err_d   = any_err_s;
      frame_cnt_d = sat_inc(frame_cnt_q);
      if (any_err_s) begin
        err_cnt_d = sat_inc(err_cnt_q);
      end else begin
        lock_d = 1'b1;
      end
      // A MAC-flagged frame carries no trustworthy classification.
      if (!s_axis_rx.tuser) begin
        if (len_err_s)  len_err_cnt_d  = sat_inc(len_err_cnt_q);
        if (seq_err_s)  seq_err_cnt_d  = sat_inc(seq_err_cnt_q);
        if (data_err_d) data_err_cnt_d = sat_inc(data_err_cnt_q);
      end else begin
        len_err_cnt_d = len_err_cnt_q;
      end
      if (hdr_ok_d) begin
        exp_seq_d = seq_d + 32'd1;
      end else begin
        exp_seq_d = exp_seq_q;
      end
    end else begin
      chk_valid_d = 1'b0;
    end
    if (i_clear) begin
      lock_d         = 1'b0;
      frame_cnt_d    = 32'd0;
      err_cnt_d      = 32'd0;
      len_err_cnt_d  = 32'd0;
      seq_err_cnt_d  = 32'd0;
      data_err_cnt_d = 32'd0;
    end else begin
      lock_d = lock_d;
    end
  end

  // State and statistics registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= S_HEAD;
      seq_q          <= 32'd0;
      len_q          <= 16'd0;
      hdr_ok_q       <= 1'b0;
      data_err_q     <= 1'b0;
      bytes_q        <= 17'd0;
      beat_q         <= 32'd1;
      exp_seq_q      <= 32'd0;
      lock_q         <= 1'b0;
      chk_valid_q    <= 1'b0;
      chk_err_q      <= 1'b0;
      frame_cnt_q    <= 32'd0;
      err_cnt_q      <= 32'd0;
      len_err_cnt_q  <= 32'd0;
      seq_err_cnt_q  <= 32'd0;
      data_err_cnt_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      seq_q          <= seq_d;
      len_q          <= len_d;
      hdr_ok_q       <= hdr_ok_d;
      data_err_q     <= data_err_d;
      bytes_q        <= bytes_d;
      beat_q         <= beat_d;
      exp_seq_q      <= exp_seq_d;
      lock_q         <= lock_d;
      chk_valid_q    <= chk_valid_d;
      chk_err_q      <= chk_err_d;
      frame_cnt_q    <= frame_cnt_d;
      err_cnt_q      <= err_cnt_d;
      len_err_cnt_q  <= len_err_cnt_d;
      seq_err_cnt_q  <= seq_err_cnt_d;
      data_err_cnt_q <= data_err_cnt_d;
    end
  end

  assign o_lock         = lock_q;
  assign o_chk_valid    = chk_valid_q;
  assign o_chk_err      = chk_err_q;
  assign o_frame_cnt    = frame_cnt_q;
  assign o_err_cnt      = err_cnt_q;
  assign o_len_err_cnt  = len_err_cnt_q;
  assign o_seq_err_cnt  = seq_err_cnt_q;
  assign o_data_err_cnt = data_err_cnt_q;

endmodule

// File: tb/tb_eth_frame_checker.sv
// Self-checking bench: directed scenarios plus randomized frames against a frame-level model.
module tb_eth_frame_checker;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_clear;
  logic        o_lock;
  logic        o_chk_valid;
  logic        o_chk_err;
  logic [31:0] o_frame_cnt;
  logic [31:0] o_err_cnt;
  logic [31:0] o_len_err_cnt;
  logic [31:0] o_seq_err_cnt;
  logic [31:0] o_data_err_cnt;

  eth_frame_checker_if #(.P_DATA_WIDTH(64)) rx_if ();

  eth_frame_checker #(
    .P_DATA_WIDTH(64),
    .P_MIN_LENGTH(16'd64),
    .P_MAX_LENGTH(16'd9600)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_clear       (i_clear),
    .s_axis_rx     (rx_if),
    .o_lock        (o_lock),
    .o_chk_valid   (o_chk_valid),
    .o_chk_err     (o_chk_err),
    .o_frame_cnt   (o_frame_cnt),
    .o_err_cnt     (o_err_cnt),
    .o_len_err_cnt (o_len_err_cnt),
    .o_seq_err_cnt (o_seq_err_cnt),
    .o_data_err_cnt(o_data_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;

  // Reference model state
  bit          m_lock = 1'b0;
  logic [31:0] m_exp = 32'd0;
  logic [31:0] m_frame = 32'd0, m_err = 32'd0, m_len = 32'd0, m_seq = 32'd0, m_data = 32'd0;
  int          m_sent = 0;
  bit          exp_q[$];

  logic [63:0] tx_data[$];
  logic [7:0]  tx_keep[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_counters(input string tag);
    check_eq({tag, ".frame_cnt"},    o_frame_cnt,    m_frame);
    check_eq({tag, ".err_cnt"},      o_err_cnt,      m_err);
    check_eq({tag, ".len_err_cnt"},  o_len_err_cnt,  m_len);
    check_eq({tag, ".seq_err_cnt"},  o_seq_err_cnt,  m_seq);
    check_eq({tag, ".data_err_cnt"}, o_data_err_cnt, m_data);
    check_eq({tag, ".lock"},         o_lock,         m_lock);
  endtask

  function automatic logic [31:0] bump(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_clear();
    m_lock = 1'b0;
    m_frame = 32'd0; m_err = 32'd0; m_len = 32'd0; m_seq = 32'd0; m_data = 32'd0;
  endtask

  // Judge the whole frame held in tx_data/tx_keep from the frame-format rules.
  task automatic model_complete(input bit tuser);
    int          n;
    int          pc;
    int          bytes;
    bit          hdr_ok, d_err, l_err, s_err, any;
    logic [31:0] seq;
    logic [15:0] lenf;
    logic [63:0] w;
    logic [7:0]  kp;
    n      = tx_data.size();
    hdr_ok = (tx_data[0][63:48] == 16'hA55A);
    seq    = tx_data[0][31:0];
    lenf   = tx_data[0][47:32];
    d_err  = !hdr_ok;
    for (int i = 0; i < n; i++) begin
      kp = tx_keep[i];
      if (i < n - 1) begin
        if (kp != 8'hFF) d_err = 1'b1;
      end else begin
        pc = $countones(kp);
        if (pc == 0 || kp != (8'hFF >> (8 - pc))) d_err = 1'b1;
      end
      if (i > 0) begin
        w = {seq, 32'(i)};
        for (int b = 0; b < 8; b++)
          if (kp[b] && tx_data[i][8*b +: 8] != w[8*b +: 8]) d_err = 1'b1;
      end
    end
    bytes = 8 * (n - 1) + $countones(tx_keep[n-1]);
    if (bytes > 65535) bytes = 65535;
    l_err = (bytes < 64) || (bytes > 9600) || (int'(lenf) != bytes);
    s_err = m_lock && hdr_ok && (seq != m_exp);
    any   = tuser || d_err || l_err || s_err;
    m_frame = bump(m_frame);
    if (any) m_err = bump(m_err);
    if (!tuser) begin
      if (l_err) m_len = bump(m_len);
      if (s_err) m_seq = bump(m_seq);
      if (d_err) m_data = bump(m_data);
    end
    if (hdr_ok) m_exp = seq + 32'd1;
    if (!any) m_lock = 1'b1;
    m_sent++;
    exp_q.push_back(any);
  endtask

  task automatic gen_frame(input logic [31:0] seq, input int nbytes, input int lenf);
    int nb;
    nb = (nbytes + 7) / 8;
    tx_data.delete();
    tx_keep.delete();
    for (int i = 0; i < nb; i++) begin
      if (i == 0) tx_data.push_back({16'hA55A, 16'(lenf), seq});
      else        tx_data.push_back({seq, 32'(i)});
      tx_keep.push_back((i == nb - 1) ? (8'hFF >> (8 * nb - nbytes)) : 8'hFF);
    end
  endtask

  // Idle cycles carry random garbage with tvalid low.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rx_if.tvalid = 1'b0;
      rx_if.tdata  = {$urandom, $urandom};
      rx_if.tkeep  = 8'($urandom);
      rx_if.tlast  = 1'($urandom);
      rx_if.tuser  = 1'($urandom);
      @(posedge i_clk); #1;
    end
  endtask

  task automatic send_frame(input bit tuser, input int gap_mode, input int clear_at);
    int n;
    int gaps;
    n = tx_data.size();
    for (int i = 0; i < n; i++) begin
      gaps = 0;
      if (gap_mode == 1 && i > 0) gaps = 1;
      else if (gap_mode == 2) gaps = $urandom_range(0, 2);
      if (gaps > 0) idle(gaps);
      if (i == n - 1) model_complete(tuser);
      rx_if.tvalid = 1'b1;
      rx_if.tdata  = tx_data[i];
      rx_if.tkeep  = tx_keep[i];
      rx_if.tlast  = (i == n - 1);
      rx_if.tuser  = (i == n - 1) ? tuser : 1'b0;
      i_clear      = (i == clear_at);
      @(posedge i_clk); #1;
      if (i == clear_at) begin
        i_clear = 1'b0;
        model_clear();
        check_counters("mid_clear");
      end
    end
    rx_if.tvalid = 1'b0;
    rx_if.tlast  = 1'b0;
    rx_if.tuser  = 1'b0;
  endtask

  // Every checker pulse must match the oldest outstanding model verdict.
  always @(negedge i_clk) begin
    if (i_rst_n === 1'b1 && o_chk_valid === 1'b1) begin
      n_pulses++;
      if (exp_q.size() == 0) check_eq("unexpected_pulse", o_chk_valid, 1'b0);
      else check_eq("chk_err", o_chk_err, exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] tx_seq;
    int          nbytes, lenf, mode, nb, b;
    bit          tuser;
    logic [31:0] seqs[6];

    i_rst_n = 1'b0;
    i_clear = 1'b0;
    rx_if.tvalid = 1'b0; rx_if.tdata = 64'd0; rx_if.tkeep = 8'd0;
    rx_if.tlast = 1'b0; rx_if.tuser = 1'b0;
    #23;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check_counters("reset");
    check_eq("reset.chk_valid", o_chk_valid, 1'b0);
    check_eq("reset.chk_err", o_chk_err, 1'b0);

    // Ten clean back-to-back 64 B frames
    for (int s = 0; s < 10; s++) begin
      gen_frame(32'(s), 64, 64);
      send_frame(1'b0, 0, -1);
      if (s == 0) check_eq("lock_after_f0", o_lock, 1'b1);
    end
    idle(2);
    check_counters("clean");
    check_eq("clean.frames", o_frame_cnt, 32'd10);
    check_eq("clean.pending", exp_q.size(), 0);

    // Length bounds
    nbytes = 63;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: nbytes = 63;
        1: nbytes = 64;
        2: nbytes = 9600;
        default: nbytes = 9601;
      endcase
      gen_frame(32'(10 + i), nbytes, nbytes);
      if (i == 0) check_eq("len63.last_keep", tx_keep[7], 8'h7F);
      send_frame(1'b0, 0, -1);
    end
    idle(2);
    check_counters("len_bounds");
    check_eq("len_bounds.len_err", o_len_err_cnt, 32'd2);

    // Sequence tracking with a lost frame and a wrap
    i_clear = 1'b1;
    @(posedge i_clk); #1;
    i_clear = 1'b0;
    model_clear();
    check_counters("idle_clear");
    seqs = '{32'd5, 32'd6, 32'd8, 32'd9, 32'hFFFF_FFFF, 32'd0};
    for (int i = 0; i < 6; i++) begin
      gen_frame(seqs[i], 64, 64);
      send_frame(1'b0, 0, -1);
    end
    idle(2);
    check_counters("seq");
    check_eq("seq.seq_err", o_seq_err_cnt, 32'd2);

    // Payload corruption, then corruption hidden by last-beat tkeep
    gen_frame(32'd1, 128, 128);
    tx_data[4] = tx_data[4] ^ (64'h1 << (8 * 2 + 3));
    send_frame(1'b0, 0, -1);
    idle(2);
    check_eq("payload.data_err", o_data_err_cnt, 32'd1);
    gen_frame(32'd2, 100, 100);
    tx_data[12] = tx_data[12] ^ (64'h1 << (8 * 6 + 3));
    send_frame(1'b0, 0, -1);
    idle(2);
    check_eq("masked.data_err", o_data_err_cnt, 32'd1);
    check_counters("payload");

    // MAC-flagged frame with tvalid gaps
    gen_frame(32'd3, 256, 256);
    send_frame(1'b1, 1, -1);
    idle(2);
    check_counters("tuser");

    // Clear in the middle of a frame
    gen_frame(32'd4, 64, 64);
    send_frame(1'b0, 0, 3);
    idle(2);
    check_eq("clear.frame_cnt", o_frame_cnt, 32'd1);
    check_eq("clear.err_cnt", o_err_cnt, 32'd0);
    check_counters("clear");

    // Reset in the middle of a frame
    gen_frame(32'd5, 64, 64);
    for (int i = 0; i < 3; i++) begin
      rx_if.tvalid = 1'b1; rx_if.tdata = tx_data[i]; rx_if.tkeep = tx_keep[i];
      rx_if.tlast = 1'b0; rx_if.tuser = 1'b0;
      @(posedge i_clk); #1;
    end
    rx_if.tvalid = 1'b0;
    i_rst_n = 1'b0;
    #3;
    check_eq("rst.frame_cnt", o_frame_cnt, 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    model_clear();
    m_exp = 32'd0;
    exp_q.delete();
    gen_frame(32'd777, 64, 64);
    send_frame(1'b0, 0, -1);
    idle(2);
    check_eq("rst.frames_after", o_frame_cnt, 32'd1);
    check_eq("rst.err_after", o_err_cnt, 32'd0);

    // Randomized frames
    tx_seq = 32'd778;
    for (int f = 0; f < 60; f++) begin
      nbytes = $urandom_range(56, 240);
      lenf   = nbytes;
      mode   = $urandom_range(0, 11);
      tuser  = 1'b0;
      if (mode == 3) lenf = nbytes + 1;
      if (mode == 4) tx_seq = tx_seq + 32'($urandom_range(1, 5));
      if (mode == 5) tuser = 1'b1;
      gen_frame(tx_seq, nbytes, lenf);
      nb = tx_data.size();
      if (mode == 0) tx_data[0] = tx_data[0] ^ 64'h0080_0000_0000_0000;
      if (mode == 1 && nb > 2) begin
        b = $urandom_range(1, nb - 2);
        tx_data[b] = tx_data[b] ^ (64'h1 << $urandom_range(0, 63));
      end
      if (mode == 2 && nb > 1) begin
        b = $urandom_range(0, nb - 2);
        tx_keep[b] = 8'hF7;
      end
      if (mode == 6) tx_keep[nb-1] = 8'h05;
      tx_seq = tx_seq + 32'd1;
      send_frame(tuser, 2 * $urandom_range(0, 1), -1);
      check_counters("rand");
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(3);
    check_eq("pulse_count", n_pulses, m_sent);
    check_eq("final.pending", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/eth_frame_checker.md
# eth_frame_checker

Receive-side traffic checker for the 40G Ethernet loopback design; it is the consuming end of the per-channel frame generator. One instance sits on each channel's MAC RX AXI-Stream and checks every received frame for length, header, sequence and payload pattern. It reports per-frame pulses and saturating statistics counters to the top-level status logic. It never back-pressures the MAC.

## Interface
- P_DATA_WIDTH, 64: AXIS data width in bits; keep width is P_DATA_WIDTH/8. Only 64 is required.
- P_MIN_LENGTH, 16'd64: minimum legal frame length in bytes, FCS excluded.
- P_MAX_LENGTH, 16'd9600: maximum legal frame length in bytes, FCS excluded.

Ports:
- i_clk  in  1  RX user clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_clear  in  1  synchronous clear of all counters and the lock flag.
- s_axis_rx_tdata  in  64  frame data; byte 0 is in bits [7:0].
- s_axis_rx_tkeep  in  8  byte enables.
- s_axis_rx_tvalid  in  1  beat valid.
- s_axis_rx_tlast  in  1  last beat of frame.
- s_axis_rx_tuser  in  1  MAC-flagged bad frame (FCS/PHY error); sampled on the tlast beat.
- o_lock  out  1  set after the first clean frame.
- o_chk_valid  out  1  one-cycle pulse per checked frame.
- o_chk_err  out  1  qualifies o_chk_valid; 1 means any error in that frame.
- o_frame_cnt  out  32  frames received.
- o_err_cnt  out  32  frames with any error.
- o_len_err_cnt, o_seq_err_cnt, o_data_err_cnt  out  32 each  per-class error counts.

## Operation
- Frame format: word 0 = {16'hA55A, len[15:0], seq[31:0]} (bits 63:48, 47:32, 31:0). Word k≥1 = {seq[31:0], k[31:0]}.
- States: S_HEAD waits for a valid beat. A valid beat latches seq, len field and header-OK, then goes to S_BODY, or stays in S_HEAD if tlast is set. S_BODY checks each valid beat and returns to S_HEAD on tlast. Invalid beats are ignored in both states.
- The beat index k is 32 bits and resets to 1 at S_HEAD exit. Comparison is per byte: only bytes with tkeep=1 are compared.
- Byte count (17-bit, saturating at 65535): 8 per non-last beat, plus the popcount of tkeep on the last beat.
- Data error: header magic mismatch; a payload byte mismatch; tkeep not 8'hFF on a non-last beat; tkeep on the last beat not contiguous from bit 0, or zero.
- Length error: byte count < P_MIN_LENGTH; byte count > P_MAX_LENGTH; len field ≠ byte count.
- Sequence error: applies only when o_lock=1 and seq ≠ expected. After every frame with a valid header, expected = received seq + 1 (wraps at 2^32). A mismatch therefore resyncs the tracker: one lost frame gives exactly one error.
- tuser=1 on the last beat marks the frame errored and counts it in o_err_cnt only. No class counter increments. The seq tracker still updates.
- o_lock sets on the first frame with no errors and stays set until i_clear or reset. Sequence is not checked before lock.
- Every counter saturates at 32'hFFFF_FFFF. A frame with several error classes increments each of those class counters once, and o_err_cnt once.
- i_clear behaviour:
  - It zeroes the counters and o_lock next cycle.
  - It does not abort an in-flight frame; that frame's completion is counted normally after the clear.
  - If i_clear coincides with a completion update, the clear wins.

## Timing
- o_chk_valid, o_chk_err and all counters update in the cycle after the tlast beat (1-cycle latency).
- Back-to-back frames are supported: a tlast beat followed immediately by the next header beat is fully checked.
- Reset values: all outputs 0, state S_HEAD, expected seq 0.
- Reset asserted mid-frame discards the partial frame. The first beat after release is treated as a header.

## Test plan
- Reset and lock: 10 clean frames of 64 B, seq 0..9.
  - Required: o_lock=1 after frame 0, o_frame_cnt=10, o_err_cnt=0, ten o_chk_valid pulses each with o_chk_err=0.
- Length bounds: clean frames of 63, 64, 9600 and 9601 B (len field correct).
  - Required: o_len_err_cnt=2, only the 63 B and 9601 B frames flagged. Last-beat tkeep for 63 B is 8'h7F.
- Sequence: lock on seq 5, then send seq 6, 8, 9, then 32'hFFFF_FFFF, 0.
  - Required: o_seq_err_cnt=2 (the 8 and the FFFF_FFFF), no error on the wrap to 0.
- Payload: flip bit 3 of byte 2 in word 4 of a 128 B frame.
  - Required: o_data_err_cnt=1, o_chk_err=1 on that frame only.
  - Repeat with the corrupted byte masked by tkeep=0 on a last beat: required no error.
- tuser and gaps: 256 B frame with tvalid toggling every other cycle and tuser=1 on tlast.
  - Required: o_err_cnt=+1, all class counters unchanged, o_frame_cnt=+1.
- Clear and reset mid-frame: assert i_clear during a frame.
  - Required: counters read 0 afterwards, then 1 after that frame completes.
  - Pulse i_rst_n low mid-frame, then send a clean frame: required o_frame_cnt=1, o_err_cnt=0.
